// File: rtl/func_vector_driver.sv
// func_vector_driver: steps a downstream 5-input function through a selectable
// vector set, holds each vector for DWELL cycles and samples the returned y on
// the last cycle of each hold. It accumulates a ones count and a 32-bit shift
// signature of the samples.
module func_vector_driver #(
  parameter int DWELL = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [4:0]  vec_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  input  logic        y,
  output logic        busy,
  output logic        done,
  output logic [5:0]  ones_count,
  output logic [31:0] signature
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value on the final cycle of a hold, which is the sample cycle.
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [4:0]  fixed_q, fixed_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  vec_q, vec_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0]  ones_q, ones_d;
  logic [31:0] sig_q, sig_d;

  // Vector table lookup. Mode 3 falls back to the mode 0 set.
  function automatic logic [4:0] vec_at(input logic [1:0] m,
                                        input logic [4:0] idx,
                                        input logic [4:0] fixed);
    logic [4:0] v;
    v = 5'b00000;
    case (m)
      2'd1: v = idx;
      2'd2: v = fixed;
      default: begin
        case (idx)
          5'd0:    v = 5'b00000;
          5'd1:    v = 5'b10000;
          5'd2:    v = 5'b01000;
          5'd3:    v = 5'b00100;
          5'd4:    v = 5'b00010;
          5'd5:    v = 5'b00001;
          5'd6:    v = 5'b11111;
          default: v = 5'b00000;
        endcase
      end
    endcase
    return v;
  endfunction

  // Index of the final vector in the set chosen by the latched mode.
  function automatic logic [4:0] last_idx(input logic [1:0] m);
    logic [4:0] l;
    case (m)
      2'd1:    l = 5'd31;
      2'd2:    l = 5'd0;
      default: l = 5'd6;
    endcase
    return l;
  endfunction

  // Next-state logic. Outputs are computed one cycle early so that every
  // output leaves a flop.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fixed_d = fixed_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ones_d  = ones_q;
    sig_d   = sig_q;
    case (state_q)
      IDLE: begin
        vec_d  = 5'b00000;
        busy_d = 1'b0;
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          fixed_d = vec_in;
          idx_d   = 5'd0;
          cnt_d   = 8'd0;
          ones_d  = 6'd0;
          sig_d   = 32'd0;
          busy_d  = 1'b1;
          // The first vector is already on a..e in the first RUN cycle.
          vec_d   = vec_at(mode, 5'd0, vec_in);
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (cnt_q == DWELL_LAST) begin
          sig_d  = {sig_q[30:0], y};
          ones_d = ones_q + {5'd0, y};
          cnt_d  = 8'd0;
          if (idx_q == last_idx(mode_q)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            vec_d   = 5'b00000;
            idx_d   = 5'd0;
          end else begin
            idx_d = idx_q + 5'd1;
            vec_d = vec_at(mode_q, idx_q + 5'd1, fixed_q);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        vec_d   = 5'b00000;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        vec_d   = 5'b00000;
      end
    endcase
  end

  // State and output registers; reset clears everything and aborts any run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      fixed_q <= 5'd0;
      idx_q   <= 5'd0;
      cnt_q   <= 8'd0;
      vec_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= 6'd0;
      sig_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fixed_q <= fixed_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ones_q  <= ones_d;
      sig_q   <= sig_d;
    end
  end

  assign {a, b, c, d, e} = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign ones_count      = ones_q;
  assign signature       = sig_q;

endmodule

// File: tb/tb_func_vector_driver.sv
// Testbench for func_vector_driver: three instances (DWELL 1, 3, 10) share
// stimulus; y is a truth-table function of each instance's own a..e.
module tb_func_vector_driver;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [4:0]  vec_in = 5'd0;
  logic [31:0] tt = 32'd0;

  logic [NI-1:0] busy_w;
  logic [NI-1:0] done_w;

  int checks = 0;
  int failures = 0;

  int          chk_seq = 0;
  int          exp_n = 0;
  int          exp_done = 0;
  bit          exp_busy_en = 1'b0;
  logic [5:0]  exp_ones = 6'd0;
  logic [31:0] exp_sig = 32'd0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=0x%0h expected=0x%0h", nm, inst, $time, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g
    localparam int DW = (gi == 0) ? 1 : ((gi == 1) ? 3 : 10);

    logic        a_l, b_l, c_l, d_l, e_l, y_l, busy_l, done_l;
    logic [4:0]  vec_l;
    logic [5:0]  ones_l;
    logic [31:0] sig_l;

    assign vec_l = {a_l, b_l, c_l, d_l, e_l};
    assign y_l   = tt[vec_l];
    assign busy_w[gi] = busy_l;
    assign done_w[gi] = done_l;

    func_vector_driver #(.DWELL(DW)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .vec_in(vec_in),
      .a(a_l), .b(b_l), .c(c_l), .d(d_l), .e(e_l), .y(y_l),
      .busy(busy_l), .done(done_l), .ones_count(ones_l), .signature(sig_l)
    );

    // Reference model: phase 0 idle, 1 run, 2 done; k counts RUN cycles from 1.
    int          ph = 0;
    int          k = 0;
    int          n = 0;
    logic [5:0]  m_ones = 6'd0;
    logic [31:0] m_sig = 32'd0;
    logic [4:0]  vecs [32];
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          last_seq = 0;

    always @(negedge clk) begin
      logic [4:0] ev;
      logic       ym;
      if (!rst_n) begin
        ph = 0; k = 0; m_ones = 6'd0; m_sig = 32'd0;
      end
      ev = (ph == 1) ? vecs[(k - 1) / DW] : 5'd0;
      check("vec", gi, {27'd0, vec_l}, {27'd0, ev});
      check("busy", gi, {31'd0, busy_l}, {31'd0, (ph == 1)});
      check("done", gi, {31'd0, done_l}, {31'd0, (ph == 2)});
      check("ones_count", gi, {26'd0, ones_l}, {26'd0, m_ones});
      check("signature", gi, sig_l, m_sig);
      busy_cnt += int'(busy_l);
      done_cnt += int'(done_l);

      if (chk_seq != last_seq) begin
        last_seq = chk_seq;
        check("final_ones", gi, {26'd0, ones_l}, {26'd0, exp_ones});
        check("final_sig", gi, sig_l, exp_sig);
        check("done_pulses", gi, 32'(done_cnt), 32'(exp_done));
        if (exp_busy_en) check("busy_cycles", gi, 32'(busy_cnt), 32'(exp_n * DW));
        busy_cnt = 0;
        done_cnt = 0;
      end

      // Advance the model across the coming rising edge.
      if (rst_n) begin
        case (ph)
          0: if (start) begin
            if (mode == 2'd1) begin
              n = 32;
              for (int i = 0; i < 32; i++) vecs[i] = 5'(i);
            end else if (mode == 2'd2) begin
              n = 1;
              vecs[0] = vec_in;
            end else begin
              n = 7;
              vecs[0] = 5'b00000;
              for (int i = 1; i <= 5; i++) vecs[i] = 5'b10000 >> (i - 1);
              vecs[6] = 5'b11111;
            end
            ph = 1; k = 1; m_ones = 6'd0; m_sig = 32'd0;
          end
          1: begin
            if (k % DW == 0) begin
              ym = tt[ev];
              m_sig = {m_sig[30:0], ym};
              m_ones = m_ones + {5'd0, ym};
            end
            if (k == n * DW) ph = 2;
            else k++;
          end
          default: ph = 0;
        endcase
      end
    end
  end

  task automatic run_start(input logic [1:0] m, input logic [4:0] v);
    @(posedge clk); #1;
    mode = m; vec_in = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int cyc;
    cyc = 0;
    while (busy_w != '0 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(nm, -1, {29'd0, busy_w}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic final_check(input logic [5:0] o, input logic [31:0] s,
                             input int nd, input int nv, input bit ben);
    exp_ones = o; exp_sig = s; exp_done = nd; exp_n = nv; exp_busy_en = ben;
    chk_seq++;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // y tied high, mode 0
    tt = 32'hFFFF_FFFF;
    run_start(2'd0, 5'd0);
    wait_idle("timeout_m0");
    final_check(6'd7, 32'h0000_007F, 1, 7, 1'b1);

    // y = a, mode 1
    tt = 32'hFFFF_0000;
    run_start(2'd1, 5'd0);
    wait_idle("timeout_m1a");
    final_check(6'd16, 32'h0000_FFFF, 1, 32, 1'b1);

    // y = e, mode 1
    tt = 32'hAAAA_AAAA;
    run_start(2'd1, 5'd0);
    wait_idle("timeout_m1e");
    final_check(6'd16, 32'h5555_5555, 1, 32, 1'b1);

    // mode 2, vec_in 10101, y = c
    tt = 32'hF0F0_F0F0;
    run_start(2'd2, 5'b10101);
    wait_idle("timeout_m2");
    final_check(6'd1, 32'h0000_0001, 1, 1, 1'b1);

    // start pulsed again in RUN cycle 5 is ignored
    tt = 32'hFFFF_FFFF;
    run_start(2'd0, 5'd0);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("timeout_restart");
    final_check(6'd7, 32'h0000_007F, 1, 7, 1'b1);

    // mode 3 behaves as mode 0
    run_start(2'd3, 5'd0);
    wait_idle("timeout_m3");
    final_check(6'd7, 32'h0000_007F, 1, 7, 1'b1);

    // reset in RUN cycle 20 of a mode 1 run
    tt = 32'hFFFF_0000;
    run_start(2'd1, 5'd0);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", -1, {29'd0, busy_w}, 32'd0);
    check("rst_done", -1, {29'd0, done_w}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_rst", -1, {29'd0, busy_w}, 32'd0);
    final_check(6'd0, 32'd0, 0, 0, 1'b0);
    run_start(2'd1, 5'd0);
    wait_idle("timeout_after_rst");
    final_check(6'd16, 32'h0000_FFFF, 1, 32, 1'b1);

    // randomized runs: random truth table, mode, vec_in; start/mode/vec_in
    // toggled during the run to confirm they are ignored
    for (int r = 0; r < 10; r++) begin
      int cyc;
      tt = $urandom;
      run_start(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      cyc = 0;
      while (busy_w != '0 && cyc < 400) begin
        mode   = 2'($urandom_range(0, 3));
        vec_in = 5'($urandom_range(0, 31));
        start  = (busy_w == 3'b111) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
      start = 1'b0;
      check("timeout_rand", r, {29'd0, busy_w}, 32'd0);
      repeat ($urandom_range(2, 6)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/func_vector_driver.md
FUNC_VECTOR_DRIVER -- requirements
Module: func_vector_driver

Interface
REQ-001 Parameter: DWELL, default 10, clock cycles each input vector is held; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low; the design has one clock and an asynchronous active-low reset.
REQ-004 Port: start  input  1  run request, sampled only in IDLE.
REQ-005 Port: mode  input  2  vector set select, latched on accepted start.
REQ-006 Port: vec_in  input  5  fixed vector for mode 2, latched on accepted start.
REQ-007 Port: a, b, c, d, e  output  1 each  registered stimulus to the downstream 5-input function; vector bit mapping {a,b,c,d,e} = vec[4:0].
REQ-008 Port: y  input  1  function result returned from the downstream function.
REQ-009 Port: busy  output  1  high while the run is in progress.
REQ-010 Port: done  output  1  single-cycle pulse at end of run.
REQ-011 Port: ones_count  output  6  number of sampled y values equal to 1 in the last run.
REQ-012 Port: signature  output  32  shift register of sampled y values, newest sample in bit 0.

Function
REQ-013 FSM states: IDLE, RUN, DONE; RUN applies vectors, DONE lasts exactly one cycle then returns to IDLE.
REQ-014 IDLE with start=1 -> RUN next cycle; mode and vec_in latched, vector index=0, dwell counter=0, ones_count=0, signature=0.
REQ-015 Vector sets:
- mode 0: 7 vectors 00000, 10000, 01000, 00100, 00010, 00001, 11111 (all-zero, each input alone a..e, all-one).
- mode 1: 32 vectors, vec = 0..31 ascending.
- mode 2: 1 vector = latched vec_in.
- mode 3: treated as mode 0.
REQ-016 First vector appears on a..e in the first RUN cycle, i.e. one cycle after the start cycle.
REQ-017 In RUN the dwell counter increments each cycle; in the cycle where counter == DWELL-1, y is sampled: signature <= {signature[30:0], y}, ones_count += y.
REQ-018 On that sample cycle: if not the last vector, index+1 and counter=0, so the new vector is driven the next cycle; if last vector, go to DONE.
REQ-019 Run length in RUN = N_vectors*DWELL cycles; done asserts in the cycle after the final sample; busy=1 exactly in RUN cycles.
REQ-020 DWELL=1: new vector every cycle, y sampled every cycle.
REQ-021 start while in RUN or DONE is ignored, with no effect on the current run.
REQ-022 a..e drive 0 in IDLE and DONE.
REQ-023 ones_count and signature hold their final values from DONE until the next accepted start.
REQ-024 ones_count cannot overflow (max 32 fits in 6 bits); signature keeps only the last 32 samples.

Reset
REQ-025 rst_n=0 immediately forces: state IDLE, a..e=0, busy=0, done=0, ones_count=0, signature=0, counters 0, latched mode/vec 0.
REQ-026 Reset asserted mid-run aborts the run with no done pulse; after release the block waits in IDLE for a new start.

Verification
REQ-027 y tied 1, mode 0, DWELL=10 -> busy high 70 cycles, one done pulse, ones_count=7, signature=0x0000007F.
REQ-028 y looped from a, mode 1, DWELL=1 -> 32 RUN cycles, ones_count=16, signature=0x0000FFFF.
REQ-029 y looped from e, mode 1, DWELL=3 -> 96 RUN cycles, ones_count=16, signature=0x55555555.
REQ-030 mode 2, vec_in=10101, y=c -> a..e=1,0,1,0,1 for DWELL cycles, ones_count=1, signature=0x00000001.
REQ-031 start pulsed again at RUN cycle 5 of a mode 0 run -> no restart, results identical to REQ-027.
REQ-032 rst_n pulsed low at RUN cycle 20 of mode 1 -> all outputs 0 immediately, no done pulse; a new start then completes normally.
